hamming_7_4_rx_ctrl: RTL

Serial receive controller for Hamming(7,4)-coded byte streams. Deserializes 7-bit codewords from a 1-bit strobed input and sequences each codeword through an internal Hamming(7,4) single-error-correcting decode. It pairs consecutive corrected nibbles into bytes (low nibble first) and presents them on a valid/ready output. Sits between the physical bit receiver and byte-level consumers, and also keeps error and overrun status.

---
 rtl/hamming_7_4_rx_ctrl_if.sv | 61 ++++++
 rtl/hamming_7_4_rx_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_7_4_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// hamming_7_4_rx_ctrl_if
//
// Bundles the serial input, status control and decoded byte output of the
// Hamming(7,4) receive controller.
//
// Modports:
//   master : the surrounding system; drives rx_bit/rx_valid/sync, the byte
//            consumer's byte_ready and clr_status; observes the outputs.
//   slave  : the receive controller itself.
//
// Signals:
//   rx_bit       serial codeword bit, codeword index 0 first
//   rx_valid     rx_bit qualifier, one bit accepted per cycle when high
//   sync         realign: drop the partial codeword and nibble phase
//   byte_out     decoded byte {hi nibble, lo nibble}
//   byte_valid   byte_out holds an unconsumed byte
//   byte_ready   consumer accepts byte_out when byte_valid && byte_ready
//   err_count    saturating count of codewords with a nonzero syndrome
//   overrun      sticky flag: a completed byte was dropped
//   clr_status   clears err_count and overrun
//   syndrome_out {hi s, lo s}, present only with HAMMING_RX_SYNDROME_EN
//
// Build option: define HAMMING_RX_SYNDROME_EN to add syndrome_out.
// ---------------------------------------------------------------------------
interface hamming_7_4_rx_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             rx_bit;
    logic             rx_valid;
    logic             sync;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_ready;
    logic [CNT_W-1:0] err_count;
    logic             overrun;
    logic             clr_status;
`ifdef HAMMING_RX_SYNDROME_EN
    logic [5:0]       syndrome_out;

    modport master (
        output rx_bit, rx_valid, sync, byte_ready, clr_status,
        input  byte_out, byte_valid, err_count, overrun, syndrome_out
    );

    modport slave (
        input  rx_bit, rx_valid, sync, byte_ready, clr_status,
        output byte_out, byte_valid, err_count, overrun, syndrome_out
    );
`else
    modport master (
        output rx_bit, rx_valid, sync, byte_ready, clr_status,
        input  byte_out, byte_valid, err_count, overrun
    );

    modport slave (
        input  rx_bit, rx_valid, sync, byte_ready, clr_status,
        output byte_out, byte_valid, err_count, overrun
    );
`endif
endinterface

// File: rtl/hamming_7_4_rx_ctrl.sv
// ---------------------------------------------------------------------------
// hamming_7_4_rx_ctrl
//
// Serial receive controller for Hamming(7,4)-coded byte streams.
// Bits arrive one per accepted cycle, codeword index 0 first, and are
// gathered into 7-bit codewords. Each completed codeword is held for one
// cycle (cw_pend) while it is syndrome-decoded and single-error corrected.
// Consecutive corrected nibbles are paired into bytes, low nibble first, and
// offered through a one-entry valid/ready output register.
//
// Codeword layout by index: 0=p1 1=p2 2=d0 3=p4 4=d1 5=d2 6=d3,
// nibble = {d3,d2,d1,d0}.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous, active-high reset; overrides every other input
//   bus   hamming_7_4_rx_ctrl_if.slave (serial input, byte output, status)
//
// Parameters:
//   CNT_W width of the saturating corrected-error counter (>= 1)
//
// Build option: define HAMMING_RX_SYNDROME_EN to add bus.syndrome_out, the
// pair of syndromes {hi s, lo s} that travels with each byte_out.
// ---------------------------------------------------------------------------
module hamming_7_4_rx_ctrl #(
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    hamming_7_4_rx_ctrl_if.slave bus
);

    typedef enum logic {
        ST_LO = 1'b0,   // next corrected nibble is the low half of a byte
        ST_HI = 1'b1    // next corrected nibble completes the byte
    } nib_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [2:0] bit_cnt;    // index of the next bit to be accepted, 0..6
    logic [5:0] shift;      // indices 0..5; index 6 goes straight to cw_reg
    logic [6:0] cw_reg;     // last completed codeword
    logic       cw_pend;    // cw_reg holds a codeword awaiting decode
    nib_state_t state;
    logic [3:0] lo_reg;     // corrected low nibble waiting for its partner
`ifdef HAMMING_RX_SYNDROME_EN
    logic [2:0] lo_syn;     // syndrome that belonged to lo_reg
`endif

    // -----------------------------------------------------------------------
    // Hamming(7,4) decode of cw_reg
    // -----------------------------------------------------------------------
    logic [2:0] syn;
    logic [6:0] flip_mask;
    logic [6:0] cw_fix;
    logic [3:0] nib;
    logic       byte_done;

    // NOTE: every signal driven in always_comb gets a value on every path
    // (here by unconditional assignment) so no latch can be inferred.
    always_comb begin
        syn[0] = ^{cw_reg[0], cw_reg[2], cw_reg[4], cw_reg[6]};
        syn[1] = ^{cw_reg[1], cw_reg[2], cw_reg[5], cw_reg[6]};
        syn[2] = ^{cw_reg[3], cw_reg[4], cw_reg[5], cw_reg[6]};

        // The syndrome is the 1-based position of the single bad bit.
        // Errors on parity positions leave the data bits untouched, and
        // double errors land on a wrong bit without any indication.
        if (syn == 3'd0) begin
            flip_mask = 7'd0;
        end else begin
            flip_mask = 7'd1 << (syn - 3'd1);
        end

        cw_fix = cw_reg ^ flip_mask;
        nib    = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};

        // A sync in the decode cycle throws the pending codeword away, so it
        // can neither finish a byte nor count as an error.
        byte_done = cw_pend && !bus.sync && (state == ST_HI);
    end

    // -----------------------------------------------------------------------
    // Collection, nibble pairing, output register and status
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only;
    // later assignments in the block override earlier ones, which is how
    // clr_status takes priority over same-cycle increments and overruns.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data holding registers are reset as well, not just
            // the control state, so no stale codeword or nibble can surface
            // after reset.
            bit_cnt        <= 3'd0;
            shift          <= 6'd0;
            cw_reg         <= 7'd0;
            cw_pend        <= 1'b0;
            state          <= ST_LO;
            lo_reg         <= 4'd0;
            bus.byte_out   <= 8'd0;
            bus.byte_valid <= 1'b0;
            bus.err_count  <= '0;
            bus.overrun    <= 1'b0;
`ifdef HAMMING_RX_SYNDROME_EN
            lo_syn           <= 3'd0;
            bus.syndrome_out <= 6'd0;
`endif
        end else begin
            // cw_pend is a single-cycle pulse unless a new codeword lands
            cw_pend <= 1'b0;

            if (bus.sync) begin
                // Realign: forget the partial codeword, any pending codeword
                // and the nibble phase. A bit arriving alongside sync becomes
                // index 0 of the new codeword.
                state   <= ST_LO;
                bit_cnt <= 3'd0;
                if (bus.rx_valid) begin
                    shift[0] <= bus.rx_bit;
                    bit_cnt  <= 3'd1;
                end
            end else begin
                // Bit collection runs in parallel with decode, so a new
                // codeword can start right after the previous one ends.
                if (bus.rx_valid) begin
                    if (bit_cnt == 3'd6) begin
                        cw_reg  <= {bus.rx_bit, shift};
                        cw_pend <= 1'b1;
                        bit_cnt <= 3'd0;
                    end else begin
                        shift[bit_cnt] <= bus.rx_bit;
                        bit_cnt        <= bit_cnt + 3'd1;
                    end
                end

                if (cw_pend) begin
                    if ((syn != 3'd0) && (bus.err_count != CNT_MAX)) begin
                        bus.err_count <= bus.err_count + CNT_W'(1);
                    end

                    case (state)
                        ST_LO: begin
                            lo_reg <= nib;
`ifdef HAMMING_RX_SYNDROME_EN
                            lo_syn <= syn;
`endif
                            state  <= ST_HI;
                        end
                        default: begin
                            state <= ST_LO;
                        end
                    endcase
                end
            end

            // One-entry output register. A byte is accepted when the slot is
            // empty or drains in this same cycle; otherwise the new byte is
            // dropped and the held byte stays stable.
            if (byte_done) begin
                if (!bus.byte_valid || bus.byte_ready) begin
                    bus.byte_out   <= {nib, lo_reg};
                    bus.byte_valid <= 1'b1;
`ifdef HAMMING_RX_SYNDROME_EN
                    bus.syndrome_out <= {syn, lo_syn};
`endif
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (bus.byte_valid && bus.byte_ready) begin
                bus.byte_valid <= 1'b0;
            end

            if (bus.clr_status) begin
                bus.err_count <= '0;
                bus.overrun   <= 1'b0;
            end
        end
    end

endmodule
